// File: rtl/swu_window_scheduler.sv
// rtl/swu_window_scheduler.sv - write/read address and flow-control sequencer for the SWU circular line buffer
module swu_window_scheduler #(
  parameter int EFF_CH   = 2,
  parameter int IFM_W    = 4,
  parameter int IFM_H    = 4,
  parameter int K_W      = 3,
  parameter int K_H      = 3,
  parameter int STRIDE   = 1,
  parameter int OFM_W    = 2,
  parameter int OFM_H    = 2,
  parameter int BUF_ROWS = 4,
  localparam int CAP     = BUF_ROWS * IFM_W * EFF_CH,
  localparam int FRAME   = IFM_H * IFM_W * EFF_CH,
  localparam int AW      = $clog2(CAP)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_inc,
  output logic          wr_allow,
  output logic [AW-1:0] wr_addr,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW-1:0] rd_addr,
  output logic          rd_last,
  output logic          frame_done
);
  localparam int CW  = $clog2(FRAME + 1);
  localparam int CCW = (EFF_CH > 1) ? $clog2(EFF_CH) : 1;
  localparam int KWW = (K_W > 1) ? $clog2(K_W) : 1;
  localparam int KHW = (K_H > 1) ? $clog2(K_H) : 1;
  localparam int OXW = (OFM_W > 1) ? $clog2(OFM_W) : 1;
  localparam int OYW = (OFM_H > 1) ? $clog2(OFM_H) : 1;

  localparam logic [CW-1:0]  FRAME_C  = CW'(FRAME);
  localparam logic [CW-1:0]  NEED0    = CW'(((K_H - 1) * IFM_W + K_W) * EFF_CH);
  localparam logic [CW-1:0]  ROW_NEED = CW'(STRIDE * IFM_W * EFF_CH);
  localparam logic [CW-1:0]  COL_NEED = CW'(STRIDE * EFF_CH);
  localparam logic [AW:0]    CAP_A    = (AW+1)'(CAP);
  localparam logic [AW:0]    ROW_A    = (AW+1)'(STRIDE * IFM_W * EFF_CH);
  localparam logic [AW:0]    COL_A    = (AW+1)'(STRIDE * EFF_CH);
  localparam logic [AW:0]    LINE_A   = (AW+1)'(IFM_W * EFF_CH);
  localparam logic [AW:0]    ONE_A    = (AW+1)'(1);
  localparam logic [AW-1:0]  WA_MAX   = AW'(CAP - 1);
  localparam logic [CCW-1:0] C_MAX    = CCW'(EFF_CH - 1);
  localparam logic [KWW-1:0] KW_MAX   = KWW'(K_W - 1);
  localparam logic [KHW-1:0] KH_MAX   = KHW'(K_H - 1);
  localparam logic [OXW-1:0] OX_MAX   = OXW'(OFM_W - 1);
  localparam logic [OYW-1:0] OY_MAX   = OYW'(OFM_H - 1);
  localparam logic           LAST0    = (K_H == 1) && (K_W == 1) && (EFF_CH == 1);

  typedef enum logic [1:0] {WAIT, ISSUE, DONE} state_t;
  state_t state;

  logic [CW-1:0]  wr_cnt, freed, need, need_row, need_nx;
  logic [AW-1:0]  row_addr, win_addr, wrow_addr, win_nx, row_nx, in_addr;
  logic [CCW-1:0] c, c_nx;
  logic [KWW-1:0] kw, kw_nx;
  logic [KHW-1:0] kh, kh_nx;
  logic [OXW-1:0] ox;
  logic [OYW-1:0] oy;
  logic           accept, hs, win_end, ox_wrap, oy_wrap, next_last;

  // Modular add for steps no larger than CAP: one conditional subtract suffices.
  function automatic logic [AW-1:0] add_mod(input logic [AW-1:0] a, input logic [AW:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + b;
    if (s >= CAP_A) s = s - CAP_A;
    return s[AW-1:0];
  endfunction

  logic [CW-1:0] occ;
  assign occ      = wr_cnt - freed;
  assign wr_allow = (32'(occ) < 32'(CAP)) && (wr_cnt < FRAME_C);
  assign accept   = wr_inc & wr_allow;
  assign hs       = rd_valid & rd_ready;
  assign win_end  = (c == C_MAX) && (kw == KW_MAX) && (kh == KH_MAX);
  assign ox_wrap  = (ox == OX_MAX);
  assign oy_wrap  = (oy == OY_MAX);
  assign row_nx   = add_mod(row_addr, LINE_A);
  assign next_last = (c_nx == C_MAX) && (kw_nx == KW_MAX) && (kh_nx == KH_MAX);

  always_comb begin
    c_nx    = c;
    kw_nx   = kw;
    kh_nx   = kh;
    in_addr = add_mod(rd_addr, ONE_A);
    if (c != C_MAX) begin
      c_nx = c + 1'b1;
    end else begin
      c_nx = '0;
      if (kw != KW_MAX) begin
        kw_nx = kw + 1'b1;
      end else begin
        kw_nx   = '0;
        kh_nx   = (kh == KH_MAX) ? '0 : kh + 1'b1;
        in_addr = row_nx;
      end
    end
    win_nx  = ox_wrap ? add_mod(wrow_addr, ROW_A) : add_mod(win_addr, COL_A);
    need_nx = ox_wrap ? need_row + ROW_NEED : need + COL_NEED;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= WAIT;
      wr_cnt <= '0; freed <= '0; wr_addr <= '0;
      need <= NEED0; need_row <= NEED0;
      rd_addr <= '0; row_addr <= '0; win_addr <= '0; wrow_addr <= '0;
      c <= '0; kw <= '0; kh <= '0; ox <= '0; oy <= '0;
      rd_valid <= 1'b0; rd_last <= 1'b0; frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        wr_cnt  <= wr_cnt + 1'b1;
        wr_addr <= (wr_addr == WA_MAX) ? '0 : wr_addr + 1'b1;
      end
      case (state)
        WAIT: if (wr_cnt >= need) begin
          state <= ISSUE; rd_valid <= 1'b1; rd_last <= LAST0;
        end
        ISSUE: if (hs) begin
          if (!win_end) begin
            c <= c_nx; kw <= kw_nx; kh <= kh_nx;
            rd_addr <= in_addr; rd_last <= next_last;
            if ((c == C_MAX) && (kw == KW_MAX)) row_addr <= row_nx;
          end else if (ox_wrap && oy_wrap) begin
            state <= DONE; rd_valid <= 1'b0; rd_last <= 1'b0; frame_done <= 1'b1;
          end else begin
            c <= '0; kw <= '0; kh <= '0;
            win_addr <= win_nx; rd_addr <= win_nx; row_addr <= win_nx; need <= need_nx;
            if (ox_wrap) begin
              ox <= '0; oy <= oy + 1'b1;
              wrow_addr <= win_nx; need_row <= need_nx;
              freed <= freed + ROW_NEED;  // rows above the next output row are dead
            end else begin
              ox <= ox + 1'b1;
            end
            if (wr_cnt >= need_nx) begin
              rd_last <= LAST0;
            end else begin
              state <= WAIT; rd_valid <= 1'b0; rd_last <= 1'b0;
            end
          end
        end
        default: begin
          state <= WAIT;
          wr_cnt <= '0; freed <= '0; wr_addr <= '0;
          need <= NEED0; need_row <= NEED0;
          rd_addr <= '0; row_addr <= '0; win_addr <= '0; wrow_addr <= '0;
          c <= '0; kw <= '0; kh <= '0; ox <= '0; oy <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_swu_window_scheduler.sv
// tb/tb_swu_window_scheduler.sv - bench for swu_window_scheduler, default and BUF_ROWS=3 instances side by side
module tb_swu_window_scheduler;
  localparam int EC = 2, IW = 4, IH = 4, KW = 3, KH = 3, S = 1, OW = 2, OH = 2;
  localparam int WS = KH * KW * EC;
  localparam int FRAME = IH * IW * EC;
  localparam int NWIN = OW * OH;

  logic clk = 1'b0, resetn = 1'b0, wr_inc = 1'b0, rd_ready = 1'b0;
  logic [1:0] wr_allow, rd_valid, rd_last, frame_done;
  logic [1:0][4:0] wr_addr, rd_addr;

  swu_window_scheduler u0 (
    .clk(clk), .resetn(resetn), .wr_inc(wr_inc), .wr_allow(wr_allow[0]), .wr_addr(wr_addr[0]),
    .rd_valid(rd_valid[0]), .rd_ready(rd_ready), .rd_addr(rd_addr[0]), .rd_last(rd_last[0]),
    .frame_done(frame_done[0]));
  swu_window_scheduler #(.BUF_ROWS(3)) u1 (
    .clk(clk), .resetn(resetn), .wr_inc(wr_inc), .wr_allow(wr_allow[1]), .wr_addr(wr_addr[1]),
    .rd_valid(rd_valid[1]), .rd_ready(rd_ready), .rd_addr(rd_addr[1]), .rd_last(rd_last[1]),
    .frame_done(frame_done[1]));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int wc[2], fr[2], rn[2];
  bit pok[2], dn[2];
  bit mdl_on = 0;
  int rec0[$], rec1[$];
  int fdc[2];
  int cyc, first_valid0, gaps0, allow_low1, lastc0, c0_valid, c0_waddr;

  function automatic int need_of(input int w);
    return (((w / OW) * S + KH - 1) * IW + (w % OW) * S + KW) * EC;
  endfunction

  function automatic int lin_of(input int n);
    int w, r;
    w = n / WS;
    r = n % WS;
    return (((w / OW) * S + r / (KW * EC)) * IW + (w % OW) * S + (r / EC) % KW) * EC + r % EC;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_stats();
    rec0.delete();
    rec1.delete();
    fdc[0] = 0; fdc[1] = 0;
    cyc = 0; first_valid0 = -1; gaps0 = 0; allow_low1 = 0; lastc0 = 0;
    c0_valid = -1; c0_waddr = -1;
  endtask

  // Cycle model: counts and read index advance from the rules, outputs derived arithmetically.
  always @(negedge clk) begin
    int cap, nr, w;
    bit ea, ev, hs;
    for (int i = 0; i < 2; i++) begin
      cap = (i == 1) ? 24 : 32;
      ea = ((wc[i] - fr[i]) < cap) && (wc[i] < FRAME);
      ev = !dn[i] && (((rn[i] % WS) != 0) || pok[i]);
      if (mdl_on) begin
        chk($sformatf("wr_allow[%0d]", i), int'(wr_allow[i]), int'(ea));
        chk($sformatf("wr_addr[%0d]", i), int'(wr_addr[i]), wc[i] % cap);
        chk($sformatf("rd_valid[%0d]", i), int'(rd_valid[i]), int'(ev));
        chk($sformatf("frame_done[%0d]", i), int'(frame_done[i]), int'(dn[i]));
        if (ev) begin
          chk($sformatf("rd_addr[%0d] n=%0d", i, rn[i]), int'(rd_addr[i]), lin_of(rn[i]) % cap);
          chk($sformatf("rd_last[%0d] n=%0d", i, rn[i]), int'(rd_last[i]), int'((rn[i] % WS) == WS - 1));
        end
        if (rd_valid[i] && rd_ready) begin
          if (i == 0) rec0.push_back(int'(rd_addr[0]));
          else rec1.push_back(int'(rd_addr[1]));
        end
        fdc[i] += int'(frame_done[i]);
        if (i == 0) begin
          if (cyc == 0) begin c0_valid = int'(rd_valid[0]); c0_waddr = int'(wr_addr[0]); end
          if (rd_valid[0] && first_valid0 < 0) first_valid0 = cyc;
          if (!rd_valid[0] && rec0.size() > 0 && rec0.size() < NWIN * WS) gaps0++;
          if (rd_valid[0] && rd_ready && rd_last[0]) lastc0++;
        end else if (!wr_allow[1] && fdc[1] == 0) begin
          allow_low1++;
        end
      end
      if (!resetn) begin
        wc[i] = 0; fr[i] = 0; rn[i] = 0; pok[i] = 0; dn[i] = 0;
      end else if (mdl_on) begin
        if (dn[i]) begin
          wc[i] = 0; fr[i] = 0; rn[i] = 0; pok[i] = 0; dn[i] = 0;
        end else begin
          hs = ev && rd_ready;
          nr = rn[i] + int'(hs);
          if (hs && (rn[i] % WS) == WS - 1) begin
            w = rn[i] / WS;
            if (w == NWIN - 1) dn[i] = 1;
            else if ((w % OW) == OW - 1) fr[i] = (w / OW + 1) * S * IW * EC;
          end
          pok[i] = (nr < NWIN * WS) ? (wc[i] >= need_of(nr / WS)) : 1'b0;
          if (wr_inc && ea) wc[i]++;
          rn[i] = nr;
        end
      end
    end
    if (!resetn) mdl_on = 1;
    cyc++;
  end

  // mode 0: writer every cycle, ready high; 1: random ready; 2: one write per 5 cycles
  task automatic run_frame(input int mode, input int target);
    int n = 0;
    while ((fdc[0] < target || fdc[1] < target) && n < 3000) begin
      wr_inc = (mode == 2) ? ((n % 5) == 0) : 1'b1;
      rd_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("frame_timeout mode=%0d", mode), int'(n < 3000), 1);
  endtask

  task automatic do_reset();
    resetn = 1'b0; wr_inc = 1'b0; rd_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    clear_stats();
  endtask

  int lit18[18] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 16, 17, 18, 19, 20, 21};
  int bad;

  initial begin
    chk("model_need0", need_of(0), 22);
    chk("model_need_last", need_of(NWIN - 1), FRAME);
    chk("model_lin_last", lin_of(NWIN * WS - 1) % 32, 31);
    chk("model_lin_wrap24", lin_of(2 * WS + 12) % 24, 0);

    clear_stats();
    do_reset();
    run_frame(0, 1);
    chk("s1_first_valid_cycle", first_valid0, 23);
    chk("s1_reads", rec0.size(), NWIN * WS);
    for (int k = 0; k < 18; k++) chk($sformatf("s1_addr%0d", k), rec0[k], lit18[k]);
    chk("s1_last_addr", rec0[NWIN * WS - 1], 31);
    chk("s1_rd_last_count", lastc0, NWIN);
    chk("s1_frame_done0", fdc[0], 1);
    chk("b3_reads", rec1.size(), NWIN * WS);
    chk("b3_win10_kh2_addr", rec1[2 * WS + 12], 0);
    chk("b3_wr_allow_dropped", int'(allow_low1 > 0), 1);

    do_reset();
    run_frame(1, 1);
    bad = 0;
    for (int k = 0; k < NWIN * WS; k++) if (rec0[k] != lin_of(k) % 32) bad++;
    chk("s2_reads", rec0.size(), NWIN * WS);
    chk("s2_seq_mismatches", bad, 0);
    chk("s2_frame_done", fdc[0], 1);

    do_reset();
    run_frame(2, 1);
    chk("s3_reads", rec0.size(), NWIN * WS);
    chk("s3_gaps_seen", int'(gaps0 > 0), 1);
    chk("s3_frame_done", fdc[1], 1);

    do_reset();
    wr_inc = 1'b1; rd_ready = 1'b1;
    for (int n = 0; n < 500 && rec0.size() < 10; n++) begin @(posedge clk); #1; end
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    chk("s4_abort_no_done", fdc[0] + fdc[1], 0);
    clear_stats();
    run_frame(0, 1);
    chk("s4_post_rst_valid", c0_valid, 0);
    chk("s4_post_rst_waddr", c0_waddr, 0);
    chk("s4_first_valid_cycle", first_valid0, 23);
    chk("s4_reads", rec0.size(), NWIN * WS);
    chk("s4_first_addr", rec0[0], 0);
    chk("s4_frame_done", fdc[0], 1);

    do_reset();
    run_frame(0, 2);
    chk("s5_frame_done0", fdc[0], 2);
    chk("s5_frame_done1", fdc[1], 2);
    chk("s5_reads", rec0.size(), 2 * NWIN * WS);
    chk("s5_second_first_addr", rec0[NWIN * WS], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/swu_window_scheduler.md
Name: swu_window_scheduler

Overview:
- Address/flow-control sequencer for the sliding-window unit's circular line buffer (single-port-write, single-port-read RAM of SIMD-wide words).
- Generates the write address for incoming IFM words and the read-address stream for every kernel window.
- Holds off reads until the window's data is resident, and holds off writes until old rows are no longer referenced.
- One instance per SWU; the RAM and the output data register live in the SWU datapath.

Parameters:
- EFF_CH, 2, channel words per pixel (IFMChannels/SIMD), >=1
- IFM_W, 4, input width in pixels
- IFM_H, 4, input height in pixels
- K_W, 3, kernel width
- K_H, 3, kernel height
- STRIDE, 1, window stride, both axes
- OFM_W, 2, output width; must equal (IFM_W-K_W)/STRIDE+1; no padding supported
- OFM_H, 2, output height; same rule
- BUF_ROWS, 4, buffer depth in IFM rows, >= K_H+STRIDE-1
- Derived: CAP = BUF_ROWS*IFM_W*EFF_CH; FRAME = IFM_H*IFM_W*EFF_CH; AW = clog2(CAP)

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- wr_inc  in  1  writer stores one word this cycle (counted only when wr_allow=1)
- wr_allow  out  1  buffer may accept a word
- wr_addr  out  AW  RAM write address for the current word
- rd_valid  out  1  rd_addr valid
- rd_ready  in  1  datapath accepts rd_addr
- rd_addr  out  AW  RAM read address
- rd_last  out  1  last word of current window (kh=K_H-1, kw=K_W-1, c=EFF_CH-1)
- frame_done  out  1  one-cycle pulse after the last window of the frame is accepted

Behaviour:
- Reset (resetn=0 at clk edge): all counters 0, state WAIT, rd_valid=0, rd_last=0, frame_done=0, wr_addr=0, rd_addr=0; wr_allow=1 after reset. A mid-frame reset abandons the frame and produces no frame_done.
- Write side:
  - wr_cnt counts accepted words, 0..FRAME. Accept = wr_inc & wr_allow; wr_inc with wr_allow=0 is ignored.
  - wr_addr = wr_cnt mod CAP, maintained incrementally, wrapping CAP-1 -> 0.
  - wr_allow = (wr_cnt - freed < CAP) & (wr_cnt < FRAME).
- Read loop order: oy, ox (outer), then kh, kw, c (c innermost).
- Linear index: L = ((oy*STRIDE+kh)*IFM_W + ox*STRIDE+kw)*EFF_CH + c; rd_addr = L mod CAP.
  - Computed with incremental adders and conditional subtract of CAP only, no multipliers or dividers in the per-cycle path.
- Window need: need = ((oy*STRIDE+K_H-1)*IFM_W + ox*STRIDE+K_W)*EFF_CH words written.
- FSM states:
  - WAIT: rd_valid=0; go to ISSUE when wr_cnt >= need (comparison on registered counts).
  - ISSUE: rd_valid=1; address and rd_last held stable while rd_ready=0; on handshake, advance c/kw/kh.
    - On handshake with rd_last=1: advance ox, wrapping to oy+1. The next window re-enters WAIT, except that a window whose need is already met goes straight to ISSUE with no bubble.
    - On handshake of rd_last for window (OFM_H-1, OFM_W-1): go to DONE.
  - DONE: frame_done=1 for exactly one cycle; clear wr_cnt, freed, all loop counters and address registers; return to WAIT.
- Freeing: on the handshake of the last word of output row oy (oy < OFM_H-1), freed <= (oy+1)*STRIDE*IFM_W*EFF_CH. freed is monotonic within a frame.
- Simultaneous events:
  - A write and a read in the same cycle are both processed.
  - A free and a write in the same cycle: wr_allow next cycle uses both updated values.
  - Read-side latency: zero extra. rd_valid rises the cycle after wr_cnt reaches need.
- A wr_inc in the DONE cycle is not accepted (wr_allow=0 since wr_cnt=FRAME); the next frame starts cleanly the cycle after.

Test Plan:
- Defaults, writer always driving, rd_ready=1:
  - rd_valid first rises the cycle after wr_cnt=22.
  - First addresses: 0,1,2,3,4,5,8,9,10,11,12,13,16..21, rd_last on 21.
  - 72 reads total; last window ends at addr 31; frame_done pulses once.
- BUF_ROWS=3 (CAP=24), defaults otherwise:
  - wr_allow drops at wr_cnt=24 and reasserts after row 0 is freed (end of window (0,1)).
  - Window (1,0), kh=2 reads row 3 pixel 0 at addr 0.
  - wr_addr wraps 23 -> 0.
- rd_ready toggling 1/0 randomly: rd_addr/rd_last stable while stalled; the address sequence is identical to the first scenario.
- Writer throttled to one word per 5 cycles: read stream contains WAIT gaps; no read is issued with wr_cnt < need.
- Assert resetn=0 mid-window (after 10 reads): next cycle rd_valid=0, wr_addr=0; no frame_done; the following frame reproduces the first scenario exactly.
- Two back-to-back frames: the second frame's first read is addr 0 after wr_cnt=22 again; exactly two frame_done pulses.
